spi_cmd_ctrl: RTL and testbench

Command sequencer behind the byte-level SPI slave in the LED matrix controller. It decodes the received MOSI byte stream into frame-buffer writes and control-register accesses. It queues a single read-response byte, which the SPI slave shifts out on MISO during the next chip-select frame. All logic is in the clk_sb domain; the SPI slave's byte strobe is consumed directly.

---
 rtl/spi_cmd_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes the SPI slave's received byte stream into frame-buffer
// writes and control-register accesses, and queues one read-response byte that
// is handed to the slave when chip select is released.
//
// Handshake semantics: there is no back-pressure in either direction.
//   mosi_rx  - one-cycle strobe; mosi_data is consumed on the same clk_sb edge.
//              A strobe may arrive every cycle.
//   miso_tx  - one-cycle request; the slave loads miso_data on that edge.
//              miso_data is held stable between loads.
//   fb_we    - one-cycle write strobe qualifying fb_addr/fb_wdata.
module spi_cmd_ctrl #(
    parameter int          ADDR_W = 11,
    parameter logic [7:0]  DEV_ID = 8'hA5
) (
    input  logic              clk_sb,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              mosi_rx,
    input  logic [7:0]        mosi_data,
    output logic              miso_tx,
    output logic [7:0]        miso_data,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_wdata,
    output logic              display_en,
    output logic [7:0]        brightness,
    output logic              swap_req,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        CMD     = 4'd1,
        FB_AH   = 4'd2,
        FB_AL   = 4'd3,
        FB_DATA = 4'd4,
        RR_IDX  = 4'd5,
        WR_IDX  = 4'd6,
        WR_DATA = 4'd7,
        DISCARD = 4'd8
    } state_t;

    state_t            state_q, state_d;

    logic              cs_meta_q, cs_sync_q, cs_del_q;
    logic              cs_fall, cs_rise, byte_ok;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        wr_idx_q;
    logic              fb_we_q;
    logic [ADDR_W-1:0] fb_addr_q;
    logic [7:0]        fb_wdata_q;

    logic              display_en_q, swap_req_q;
    logic [7:0]        bright_q;
    logic              err_cmd_q, resp_ovr_q;

    logic              resp_pending_q, miso_tx_q;
    logic [7:0]        miso_data_q;
    logic [7:0]        reg_rd;

    logic              ah_fire, al_fire, fb_fire, rr_fire, wi_fire, wd_fire, bad_fire;

    // The sync flops reset to "selected" so that a reset in mid-frame cannot
    // fabricate a falling edge: the rest of that frame is ignored until cs_n
    // is released and asserted again.
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta_q <= 1'b0;
            cs_sync_q <= 1'b0;
            cs_del_q  <= 1'b0;
        end else begin
            cs_meta_q <= cs_n;
            cs_sync_q <= cs_meta_q;
            cs_del_q  <= cs_sync_q;
        end
    end

    assign cs_fall = cs_del_q & ~cs_sync_q;
    assign cs_rise = ~cs_del_q & cs_sync_q;
    // A byte arriving once synced cs_n is high (including the rise cycle) is dropped.
    assign byte_ok = mosi_rx & ~cs_sync_q;

    // State register.
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic and per-byte action decode.
    always_comb begin
        state_d  = state_q;
        ah_fire  = 1'b0;
        al_fire  = 1'b0;
        fb_fire  = 1'b0;
        rr_fire  = 1'b0;
        wi_fire  = 1'b0;
        wd_fire  = 1'b0;
        bad_fire = 1'b0;
        if (cs_sync_q) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD: if (byte_ok) begin
                    case (mosi_data)
                        8'h01:   state_d = FB_AH;
                        8'h02:   state_d = RR_IDX;
                        8'h03:   state_d = WR_IDX;
                        default: begin
                            state_d  = DISCARD;
                            bad_fire = 1'b1;
                        end
                    endcase
                end
                FB_AH: if (byte_ok) begin
                    state_d = FB_AL;
                    ah_fire = 1'b1;
                end
                FB_AL: if (byte_ok) begin
                    state_d = FB_DATA;
                    al_fire = 1'b1;
                end
                FB_DATA: fb_fire = byte_ok;
                RR_IDX: if (byte_ok) begin
                    state_d = DISCARD;
                    rr_fire = 1'b1;
                end
                WR_IDX: if (byte_ok) begin
                    state_d = WR_DATA;
                    wi_fire = 1'b1;
                end
                WR_DATA: if (byte_ok) begin
                    state_d = DISCARD;
                    wd_fire = 1'b1;
                end
                DISCARD: state_d = DISCARD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Register read mux, indexed by the incoming index byte.
    always_comb begin
        reg_rd = 8'h00;
        case (mosi_data[1:0])
            2'd0: reg_rd = {7'b0, display_en_q};
            2'd1: reg_rd = bright_q;
            2'd2: reg_rd = {6'b0, resp_ovr_q, err_cmd_q};
            2'd3: reg_rd = DEV_ID;
            default: reg_rd = 8'h00;
        endcase
    end

    // Frame-buffer address tracking and registered write port.
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= 8'h00;
        end else begin
            fb_we_q <= fb_fire;
            if (ah_fire) addr_q[ADDR_W-1:8] <= mosi_data[ADDR_W-9:0];
            if (al_fire) addr_q[7:0] <= mosi_data;
            if (fb_fire) begin
                fb_addr_q  <= addr_q;
                fb_wdata_q <= mosi_data;
                addr_q     <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Control registers, status flags and swap pulse.
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx_q     <= 2'd0;
            display_en_q <= 1'b0;
            bright_q     <= 8'h80;
            swap_req_q   <= 1'b0;
            err_cmd_q    <= 1'b0;
            resp_ovr_q   <= 1'b0;
        end else begin
            swap_req_q <= 1'b0;
            if (wi_fire) wr_idx_q <= mosi_data[1:0];
            if (wd_fire) begin
                if (wr_idx_q == 2'd0) begin
                    display_en_q <= mosi_data[0];
                    swap_req_q   <= mosi_data[1];
                end else if (wr_idx_q == 2'd1) begin
                    bright_q <= mosi_data;
                end
            end
            // Reading STATUS clears it; a new error event in the same cycle wins.
            if (bad_fire) err_cmd_q <= 1'b1;
            else if (rr_fire && mosi_data[1:0] == 2'd2) err_cmd_q <= 1'b0;
            if (rr_fire && resp_pending_q) resp_ovr_q <= 1'b1;
            else if (rr_fire && mosi_data[1:0] == 2'd2) resp_ovr_q <= 1'b0;
        end
    end

    // Read-response capture and hand-off to the slave at frame end.
    always_ff @(posedge clk_sb or negedge reset_n) begin
        if (!reset_n) begin
            miso_data_q    <= 8'h00;
            resp_pending_q <= 1'b0;
            miso_tx_q      <= 1'b0;
        end else begin
            miso_tx_q <= cs_rise & resp_pending_q;
            if (rr_fire) begin
                miso_data_q    <= reg_rd;
                resp_pending_q <= 1'b1;
            end else if (cs_rise) begin
                resp_pending_q <= 1'b0;
            end
        end
    end

    assign miso_tx    = miso_tx_q;
    assign miso_data  = miso_data_q;
    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign display_en = display_en_q;
    assign brightness = bright_q;
    assign swap_req   = swap_req_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed bench for spi_cmd_ctrl with scoreboards for frame-buffer writes
// and read-response hand-offs.
module tb_spi_cmd_ctrl;

  logic        clk_sb = 1'b0;
  logic        reset_n;
  logic        cs_n;
  logic        mosi_rx;
  logic [7:0]  mosi_data;
  logic        miso_tx;
  logic [7:0]  miso_data;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        display_en;
  logic [7:0]  brightness;
  logic        swap_req;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int swap_cnt = 0;
  int miso_cnt = 0;
  int fb_cnt = 0;

  logic [18:0] exp_q[$];
  logic [7:0]  exp_miso_q[$];

  spi_cmd_ctrl #(.ADDR_W(11), .DEV_ID(8'hA5)) dut (
    .clk_sb     (clk_sb),
    .reset_n    (reset_n),
    .cs_n       (cs_n),
    .mosi_rx    (mosi_rx),
    .mosi_data  (mosi_data),
    .miso_tx    (miso_tx),
    .miso_data  (miso_data),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .display_en (display_en),
    .brightness (brightness),
    .swap_req   (swap_req),
    .state_dbg  (state_dbg)
  );

  // clock
  always #5 clk_sb = ~clk_sb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: DUT outputs sampled on the falling edge
  always @(negedge clk_sb) begin
    if (fb_we === 1'b1) begin
      fb_cnt++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL fb_unexpected observed=%0h/%0h expected=none", fb_addr, fb_wdata);
      end
      if (exp_q.size() > 0) check("fb_write", {13'b0, fb_addr, fb_wdata}, {13'b0, exp_q.pop_front()});
    end
    if (miso_tx === 1'b1) begin
      miso_cnt++;
      checks++;
      assert (exp_miso_q.size() > 0) else begin
        errors++;
        $error("FAIL miso_unexpected observed=%0h expected=none", miso_data);
      end
      if (exp_miso_q.size() > 0) check("miso_data", {24'b0, miso_data}, {24'b0, exp_miso_q.pop_front()});
    end
    if (swap_req === 1'b1) swap_cnt++;
  end

  // driver tasks; all called at posedge+1
  task automatic frame_start();
    cs_n = 1'b0;
    repeat (4) @(posedge clk_sb);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    mosi_rx = 1'b1;
    mosi_data = b;
    @(posedge clk_sb);
    #1;
    mosi_rx = 1'b0;
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    repeat (6) @(posedge clk_sb);
    #1;
  endtask

  task automatic push_fb(input logic [10:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    int m0;
    int f0;
    reset_n = 1'b0;
    cs_n = 1'b1;
    mosi_rx = 1'b0;
    mosi_data = 8'h00;
    repeat (3) @(posedge clk_sb);
    #1;
    check("rst_fb_we", {31'b0, fb_we}, 32'd0);
    check("rst_fb_addr", {21'b0, fb_addr}, 32'd0);
    check("rst_fb_wdata", {24'b0, fb_wdata}, 32'd0);
    check("rst_miso_tx", {31'b0, miso_tx}, 32'd0);
    check("rst_miso_data", {24'b0, miso_data}, 32'd0);
    check("rst_display_en", {31'b0, display_en}, 32'd0);
    check("rst_brightness", {24'b0, brightness}, 32'h80);
    check("rst_swap_req", {31'b0, swap_req}, 32'd0);
    check("rst_state", {28'b0, state_dbg}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk_sb);
    #1;

    // burst write with back-to-back strobes
    push_fb(11'h010, 8'hAA); push_fb(11'h011, 8'hBB); push_fb(11'h012, 8'hCC);
    frame_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    frame_end();
    check("fb_burst_count", fb_cnt, 3);

    // address wrap at 2^11
    push_fb(11'h7FF, 8'h11); push_fb(11'h000, 8'h22);
    frame_start();
    send_byte(8'h01); send_byte(8'h07); send_byte(8'hFF);
    send_byte(8'h11); send_byte(8'h22);
    frame_end();
    check("fb_wrap_count", fb_cnt, 5);

    // register writes
    frame_start();
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h40);
    frame_end();
    check("brightness_40", {24'b0, brightness}, 32'h40);
    frame_start();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h03);
    frame_end();
    check("display_en_set", {31'b0, display_en}, 32'd1);
    check("swap_pulse_count", swap_cnt, 1);

    // CTRL readback: bit1 not stored
    exp_miso_q.push_back(8'h01);
    frame_start();
    send_byte(8'h02); send_byte(8'h00);
    frame_end();

    // ID read, then an empty frame must not produce miso_tx
    exp_miso_q.push_back(8'hA5);
    frame_start();
    send_byte(8'h02); send_byte(8'h03);
    frame_end();
    check("miso_count_after_id", miso_cnt, 2);
    frame_start();
    frame_end();
    check("miso_count_empty_frame", miso_cnt, 2);

    // bad command: no writes, err flag set then cleared by STATUS read
    f0 = fb_cnt;
    frame_start();
    send_byte(8'h7E); send_byte(8'h01); send_byte(8'h02);
    frame_end();
    check("bad_cmd_no_write", fb_cnt, f0);
    exp_miso_q.push_back(8'h01);
    frame_start();
    send_byte(8'h02); send_byte(8'h02);
    frame_end();
    exp_miso_q.push_back(8'h00);
    frame_start();
    send_byte(8'h02); send_byte(8'h02);
    frame_end();
    check("miso_count_status", miso_cnt, 4);

    // abort after high address byte, then a register write
    frame_start();
    send_byte(8'h01); send_byte(8'h00);
    frame_end();
    frame_start();
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h55);
    frame_end();
    check("abort_no_write", fb_cnt, f0);
    check("brightness_55", {24'b0, brightness}, 32'h55);

    // byte coincident with synced cs_n rise is dropped
    push_fb(11'h020, 8'h31); push_fb(11'h021, 8'h32);
    frame_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
    cs_n = 1'b1;
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33);
    repeat (5) @(posedge clk_sb);
    #1;
    check("cs_wins_count", fb_cnt, f0 + 2);

    // asynchronous reset in the middle of a write frame
    push_fb(11'h040, 8'h11);
    frame_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h40); send_byte(8'h11);
    @(posedge clk_sb);
    #1;
    m0 = miso_cnt;
    reset_n = 1'b0;
    #2;
    check("mid_rst_fb_we", {31'b0, fb_we}, 32'd0);
    check("mid_rst_brightness", {24'b0, brightness}, 32'h80);
    check("mid_rst_display_en", {31'b0, display_en}, 32'd0);
    check("mid_rst_miso_data", {24'b0, miso_data}, 32'd0);
    check("mid_rst_state", {28'b0, state_dbg}, 32'd0);
    @(posedge clk_sb);
    #1;
    reset_n = 1'b1;
    @(posedge clk_sb);
    #1;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    frame_end();
    check("mid_rst_write_count", fb_cnt, f0 + 3);
    check("mid_rst_no_miso", miso_cnt, m0);

    // scoreboard drained
    check("fb_queue_empty", exp_q.size(), 0);
    check("miso_queue_empty", exp_miso_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
